// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch run-control block.
package stopwatch_pkg;

    localparam int unsigned NBIT_DEF      = 18;
    localparam int unsigned DIV_LIMIT_DEF = 250000;
    localparam int unsigned DB_W_DEF      = 16;
    localparam int unsigned DB_CYCLES_DEF = 50000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } sw_state_e;

    // Digit chain is frozen whenever the stopwatch is not counting.
    function automatic logic is_frozen(input sw_state_e s);
        return (s == IDLE) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, level debouncer, press-event pulse.
module btn_debounce #(
    parameter int unsigned DB_W      = 16,
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic evt_o
);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            evt_q, evt_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        evt_d   = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
                evt_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchronizer and debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: button conditioning, run/pause/lap FSM,
// overflow freeze. Optional lap feature enabled by STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned nBit      = NBIT_DEF,
    parameter int unsigned DIV_LIMIT = DIV_LIMIT_DEF,
    parameter int unsigned DB_W      = DB_W_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic            clk_base,
    input  logic            reset,
    input  logic            btn_ss,
    input  logic            btn_lap,
    input  logic            btn_clr,
    input  logic            ovf,
    output logic            stop,
    output logic            count_clr,
    output logic            display_hold,
    output logic [nBit-1:0] limit,
    output logic [1:0]      state,
    output logic            ovf_flag
);

    logic ss_evt, lap_evt, clr_evt;

    sw_state_e state_q, state_d;
    logic      flag_q, flag_d;
    logic      clr_q, clr_d;
    logic      stop_q, stop_d;

    btn_debounce #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk       (clk_base),
        .rst_n     (reset),
        .btn_raw_i (btn_ss),
        .evt_o     (ss_evt)
    );

    btn_debounce #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk       (clk_base),
        .rst_n     (reset),
        .btn_raw_i (btn_clr),
        .evt_o     (clr_evt)
    );

`ifdef STOPWATCH_LAP_EN
    btn_debounce #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk       (clk_base),
        .rst_n     (reset),
        .btn_raw_i (btn_lap),
        .evt_o     (lap_evt)
    );
`else
    logic lap_unused;
    assign lap_unused = btn_lap;
    assign lap_evt    = 1'b0;
`endif

    // Next state: clear beats overflow, overflow beats buttons, ss beats lap.
    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        clr_d   = 1'b0;
        if (clr_evt) begin
            state_d = IDLE;
            flag_d  = 1'b0;
            clr_d   = 1'b1;
        end else if (ovf) begin
            flag_d = 1'b1;
            if ((state_q == RUN) || (state_q == LAP)) begin
                state_d = PAUSE;
            end
        end else begin
            case (state_q)
                IDLE:    if (ss_evt) state_d = RUN;
                RUN:     if (ss_evt) state_d = PAUSE;
                         else if (lap_evt) state_d = LAP;
                PAUSE:   if (ss_evt && !flag_q) state_d = RUN;
                LAP:     if (ss_evt) state_d = PAUSE;
                         else if (lap_evt) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
        stop_d = is_frozen(state_d);
    end

    // FSM and decoded outputs all update on the same edge.
    always_ff @(posedge clk_base or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            flag_q  <= 1'b0;
            clr_q   <= 1'b0;
            stop_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            clr_q   <= clr_d;
            stop_q  <= stop_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic hold_q;

    // Display latch frozen only while viewing a lap.
    always_ff @(posedge clk_base or negedge reset) begin
        if (!reset) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= (state_d == LAP);
        end
    end

    assign display_hold = hold_q;
`else
    assign display_hold = 1'b0;
`endif

    assign stop      = stop_q;
    assign count_clr = clr_q;
    assign state     = state_q;
    assign ovf_flag  = flag_q;
    assign limit     = nBit'(DIV_LIMIT);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DB_CYCLES = 4).
module tb_stopwatch_ctrl;

    localparam int unsigned NBIT = 18;
    localparam int unsigned DIVL = 250000;
    localparam int unsigned DBW  = 16;
    localparam int unsigned DBC  = 4;

`ifdef STOPWATCH_LAP_EN
    localparam logic [1:0] LAP_ST = 2'b11;
    localparam logic       LAP_HD = 1'b1;
`else
    localparam logic [1:0] LAP_ST = 2'b01;
    localparam logic       LAP_HD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            btn_ss = 1'b0;
    logic            btn_lap = 1'b0;
    logic            btn_clr = 1'b0;
    logic            ovf = 1'b0;
    logic            stop, count_clr, display_hold, ovf_flag;
    logic [NBIT-1:0] limit;
    logic [1:0]      state;

    int checks = 0;
    int errors = 0;
    int clr_total = 0;

    typedef struct {
        string      name;
        logic       ss, lap, clr, ovf;
        logic [1:0] st;
        logic       stp, hold, flag;
        int         nclr;
    } vec_t;

    vec_t tbl[20];
    vec_t sb[$];

    stopwatch_ctrl #(
        .nBit(NBIT), .DIV_LIMIT(DIVL), .DB_W(DBW), .DB_CYCLES(DBC)
    ) dut (
        .clk_base     (clk),
        .reset        (rst_n),
        .btn_ss       (btn_ss),
        .btn_lap      (btn_lap),
        .btn_clr      (btn_clr),
        .ovf          (ovf),
        .stop         (stop),
        .count_clr    (count_clr),
        .display_hold (display_hold),
        .limit        (limit),
        .state        (state),
        .ovf_flag     (ovf_flag)
    );

    always #5 clk = ~clk;

    // Count every cycle with count_clr high.
    always @(negedge clk) begin
        if (count_clr) clr_total <= clr_total + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic ss, input logic lap,
                                input logic clr, input logic ov, input logic [1:0] st,
                                input logic stp, input logic hold, input logic flag,
                                input int nclr);
        vec_t v;
        v.name = name; v.ss = ss; v.lap = lap; v.clr = clr; v.ovf = ov;
        v.st = st; v.stp = stp; v.hold = hold; v.flag = flag; v.nclr = nclr;
        return v;
    endfunction

    // Press buttons, fire ovf in the event cycle, release, then score.
    task automatic apply(input vec_t v);
        vec_t e;
        int   base;
        sb.push_back(v);
        base    = clr_total;
        btn_ss  = v.ss;
        btn_lap = v.lap;
        btn_clr = v.clr;
        tick(2 + DBC);
        ovf = v.ovf;
        tick(1);
        ovf = 1'b0;
        if (v.ovf) check({v.name, "_stop_next"}, 32'(stop), 32'(v.stp));
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
        tick(12);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: got empty scoreboard expected entry", v.name);
        end else begin
            e = sb.pop_front();
            check({e.name, "_state"}, 32'(state), 32'(e.st));
            check({e.name, "_stop"}, 32'(stop), 32'(e.stp));
            check({e.name, "_hold"}, 32'(display_hold), 32'(e.hold));
            check({e.name, "_flag"}, 32'(ovf_flag), 32'(e.flag));
            check({e.name, "_nclr"}, 32'(clr_total - base), 32'(e.nclr));
        end
    endtask

    initial begin
        //               name        ss lap clr ovf  st     stp hold   flag nclr
        tbl[0]  = mk("ovf_run",     0, 0, 0, 1, 2'b10, 1, 0,      1, 0);
        tbl[1]  = mk("ss_ignored",  1, 0, 0, 0, 2'b10, 1, 0,      1, 0);
        tbl[2]  = mk("clr_flag",    0, 0, 1, 0, 2'b00, 1, 0,      0, 1);
        tbl[3]  = mk("ss_start",    1, 0, 0, 0, 2'b01, 0, 0,      0, 0);
        tbl[4]  = mk("lap_in",      0, 1, 0, 0, LAP_ST, 0, LAP_HD, 0, 0);
        tbl[5]  = mk("ss_pause",    1, 0, 0, 0, 2'b10, 1, 0,      0, 0);
        tbl[6]  = mk("ss_resume",   1, 0, 0, 0, 2'b01, 0, 0,      0, 0);
        tbl[7]  = mk("lap_in2",     0, 1, 0, 0, LAP_ST, 0, LAP_HD, 0, 0);
        tbl[8]  = mk("lap_out",     0, 1, 0, 0, 2'b01, 0, 0,      0, 0);
        tbl[9]  = mk("ss_clr",      1, 0, 1, 0, 2'b00, 1, 0,      0, 1);
        tbl[10] = mk("ss_start2",   1, 0, 0, 0, 2'b01, 0, 0,      0, 0);
        tbl[11] = mk("ss_lap",      1, 1, 0, 0, 2'b10, 1, 0,      0, 0);
        tbl[12] = mk("ovf_pause",   0, 0, 0, 1, 2'b10, 1, 0,      1, 0);
        tbl[13] = mk("clr_ovf",     0, 0, 1, 1, 2'b00, 1, 0,      0, 1);
        tbl[14] = mk("ss_start3",   1, 0, 0, 0, 2'b01, 0, 0,      0, 0);
        tbl[15] = mk("lap_clr",     0, 1, 1, 0, 2'b00, 1, 0,      0, 1);
        tbl[16] = mk("ovf_idle",    0, 0, 0, 1, 2'b00, 1, 0,      1, 0);
        tbl[17] = mk("clr_idle",    0, 0, 1, 0, 2'b00, 1, 0,      0, 1);
        tbl[18] = mk("ss_start4",   1, 0, 0, 0, 2'b01, 0, 0,      0, 0);
        tbl[19] = mk("ss_pause2",   1, 0, 0, 0, 2'b10, 1, 0,      0, 0);

        // Reset state
        tick(3);
        check("limit_in_reset", 32'(limit), DIVL);
        check("stop_in_reset", 32'(stop), 32'd1);
        rst_n = 1'b1;
        tick(2);
        check("rst_stop", 32'(stop), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_hold", 32'(display_hold), 32'd0);
        check("rst_flag", 32'(ovf_flag), 32'd0);
        check("rst_count_clr", 32'(count_clr), 32'd0);
        check("rst_limit", 32'(limit), DIVL);

        // Bouncing ss never stable long enough
        for (int i = 0; i < 10; i++) begin
            btn_ss = (i % 2 == 0);
            tick(2);
        end
        btn_ss = 1'b0;
        tick(12);
        check("bounce_state", 32'(state), 32'd0);
        check("bounce_stop", 32'(stop), 32'd1);

        // Press latency: event after 2 + DBC edges, state on the next
        btn_ss = 1'b1;
        tick(2 + DBC);
        check("lat_state_early", 32'(state), 32'd0);
        tick(1);
        check("lat_state", 32'(state), 32'd1);
        check("lat_stop", 32'(stop), 32'd0);
        tick(3);
        btn_ss = 1'b0;
        tick(12);
        check("release_state", 32'(state), 32'd1);

        foreach (tbl[i]) apply(tbl[i]);

        // From PAUSE: clear back to IDLE
        apply(mk("clr_final", 0, 0, 1, 0, 2'b00, 1, 0, 0, 1));

        // Reset mid-debounce with button released during reset
        btn_ss = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        btn_ss = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(15);
        check("rst_abort_state", 32'(state), 32'd0);
        check("rst_abort_stop", 32'(stop), 32'd1);

        // Button held across reset must be re-accepted in full
        btn_ss = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2 + DBC);
        check("rst_held_early", 32'(state), 32'd0);
        tick(1);
        check("rst_held_state", 32'(state), 32'd1);
        check("rst_held_stop", 32'(stop), 32'd0);
        btn_ss = 1'b0;
        tick(12);
        check("rst_held_final", 32'(state), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
